gray_tracker: RTL and testbench
===============================

Name: gray_tracker

Overview:
- Downstream consumer of the 3-bit Gray-code counter stage.
- Each cycle it samples the counter's Gray value and Overflow flag and decodes Gray to binary.
- It checks that every change is a legal single forward step and extends the count with a wrap counter.
- It raises a sticky fault on any illegal step or Overflow inconsistency. Fault/Locked feed the status logic; Count feeds timing logic.

Parameters:
- WRAP_W, 8, width of the wrap (7->0 rollover) counter; Count width is WRAP_W+3.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset; shared with the upstream counter.
- Clear  input  1  synchronous fault clear; returns to SYNC, leaves Count intact.
- GrayIn  input  3  Gray value from upstream counter.
- OverflowIn  input  1  upstream sticky overflow flag.
- Bin  output  3  registered binary decode of the last accepted GrayIn.
- Count  output  WRAP_W+3  registered {wraps, Bin}.
- WrapPulse  output  1  one-cycle pulse on an accepted 7->0 step.
- StepErr  output  1  one-cycle pulse on a detected illegal event.
- Fault  output  1  sticky error flag.
- Locked  output  1  high in TRACK state.
- Sat  output  1  wrap counter reached all-ones; sticky until Reset.

Behaviour:
- Decode: b[2]=g[2]; b[1]=g[2]^g[1]; b[0]=b[1]^g[0]. Purely combinational on GrayIn, registered on accept.
- All outputs are registered; latency is 1 cycle from a GrayIn change to the Bin/Count update.
- Internal state: prev_bin (3b), prev_ovf (1b), wraps (WRAP_W), FSM {SYNC, TRACK, FAULT}.
- Reset (any state, mid-operation included): FSM=SYNC. Bin, Count, wraps, prev_bin, prev_ovf, WrapPulse, StepErr, Fault, Locked and Sat all go to 0.
- SYNC: on the first edge, latch prev_bin=decode(GrayIn), prev_ovf=OverflowIn, Bin=decode(GrayIn); wraps unchanged; go to TRACK. No checks in this cycle.
- TRACK, with d = decode(GrayIn) - prev_bin (mod 8):
  - d==0 and OverflowIn==prev_ovf: hold; no pulses.
  - d==1, no wrap (prev_bin!=7): accept; Bin updates. OverflowIn must equal prev_ovf.
  - d==1 with prev_bin==7 (wrap): accept; WrapPulse=1; wraps+=1. If wraps is all-ones, hold it and set Sat.
  - Overflow rule on a wrap: if prev_ovf==0, OverflowIn must be 1 in the same sample; if prev_ovf==1, it must stay 1.
  - Illegal events: d in {2..7}; OverflowIn 0->1 without a wrap; OverflowIn 1->0 at any time; OverflowIn still 0 on the first wrap.
  - On an illegal event: StepErr=1 for one cycle, Fault=1, go to FAULT. Bin, Count and wraps hold their pre-error values.
- FAULT: ignore inputs; outputs hold; Locked=0.
  - Clear=1: Fault=0, go to SYNC (resynchronises next edge).
  - Clear in TRACK or SYNC has no effect.
- Simultaneous events:
  - Reset beats Clear and all checks.
  - If a wrap and an overflow error occur in the same sample, the error wins: no WrapPulse, wraps unchanged.
- Locked = (FSM==TRACK), registered.
- Upstream undefined output (X) is not modelled; X on GrayIn is a bench error.

Decomposition:
- Shared package: FSM state encoding (SYNC=2'd0, TRACK=2'd1, FAULT=2'd2); GRAY_W=3; gray-to-binary decode function.
- One natural sub-module: gray2bin (3-bit combinational decoder), instantiated once.
- FSM, step check and wrap counter stay in gray_tracker.

Test Plan:
- Reset, then drive the upstream sequence 000,001,011,010,110,111,101,100 one step per cycle. Expect Bin=0..7 one cycle later each, Locked=1 from the 2nd edge, no StepErr.
- Continue with 100->000 and OverflowIn rising in the same cycle. Expect WrapPulse=1 for one cycle, Count=8 (wraps=1, Bin=0), Fault=0; a second wrap with OverflowIn held 1 gives Count=16.
- In TRACK at Bin=2 (GrayIn=011), jump to GrayIn=110 (d=2). Expect StepErr pulse, Fault=1, Locked=0, Count held at 2; then Clear=1 for one cycle gives SYNC, and TRACK with Bin=4 on the next edge.
- Wrap 7->0 with OverflowIn left at 0. Expect StepErr, Fault=1, no WrapPulse, wraps unchanged; separately, OverflowIn 0->1 while GrayIn holds 011 also gives Fault=1.
- WRAP_W=2, drive 4 wraps. Expect wraps=3 and Sat=1 after the 3rd wrap, held at 3 on the 4th; Reset asserted mid-sequence clears Count, Sat and Fault to 0 next edge, state SYNC.
- Hold GrayIn constant for 10 cycles in TRACK. Expect no pulses and all outputs stable; Clear asserted in TRACK has no effect.

Source files
------------

// File: rtl/gray_tracker_pkg.sv
// Shared types and helpers for the Gray-code tracker.
package gray_tracker_pkg;

    localparam int unsigned GRAY_W = 3;

    typedef enum logic [1:0] {
        StSync  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } state_e;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_W-1:0] gray2bin_f(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

endpackage

// File: rtl/gray_tracker_if.sv
// Bus between the upstream Gray counter / status logic and the tracker.
interface gray_tracker_if #(
    parameter int unsigned WRAP_W = 8
);
    import gray_tracker_pkg::*;

    logic                  Clear;
    logic [GRAY_W-1:0]     GrayIn;
    logic                  OverflowIn;
    logic [GRAY_W-1:0]     Bin;
    logic [WRAP_W+2:0]     Count;
    logic                  WrapPulse;
    logic                  StepErr;
    logic                  Fault;
    logic                  Locked;
    logic                  Sat;

    // Upstream side: drives the counter value and clear, observes status.
    modport master (
        output Clear, GrayIn, OverflowIn,
        input  Bin, Count, WrapPulse, StepErr, Fault, Locked, Sat
    );

    // Tracker side.
    modport slave (
        input  Clear, GrayIn, OverflowIn,
        output Bin, Count, WrapPulse, StepErr, Fault, Locked, Sat
    );

endinterface

// File: rtl/gray_tracker_gray2bin.sv
// 3-bit combinational Gray-to-binary decoder.
module gray_tracker_gray2bin
    import gray_tracker_pkg::*;
(
    input  logic [GRAY_W-1:0] gray_i,
    output logic [GRAY_W-1:0] bin_o
);

    // Pure decode, no state.
    always_comb begin
        bin_o = gray2bin_f(gray_i);
    end

endmodule

// File: rtl/gray_tracker.sv
// Tracks an upstream 3-bit Gray counter: checks single forward steps,
// extends the count with a saturating wrap counter, flags faults.
module gray_tracker
    import gray_tracker_pkg::*;
#(
    parameter int unsigned WRAP_W = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    gray_tracker_if.slave  bus
);

    state_e              state_q, state_d;
    // bin_q doubles as prev_bin: both only change on an accepted sample.
    logic [GRAY_W-1:0]   bin_q, bin_d;
    logic                prev_ovf_q, prev_ovf_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic                step_err_q, step_err_d;
    logic                fault_q, fault_d;
    logic                locked_q, locked_d;
    logic                sat_q, sat_d;

    logic [GRAY_W-1:0]   dec;
    logic [GRAY_W-1:0]   delta;
    logic                is_wrap;
    logic                bad_step;
    logic                bad_ovf;

    gray_tracker_gray2bin u_gray2bin (
        .gray_i (bus.GrayIn),
        .bin_o  (dec)
    );

    // Step classification against the last accepted value.
    always_comb begin
        delta    = dec - bin_q;
        is_wrap  = (delta == 3'd1) && (bin_q == 3'd7);
        bad_step = (delta >= 3'd2);
        // A wrap needs overflow high afterwards; otherwise overflow must not move.
        bad_ovf  = is_wrap ? !bus.OverflowIn : (bus.OverflowIn != prev_ovf_q);
    end

    // Next-state, checks and wrap counter.
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        prev_ovf_d   = prev_ovf_q;
        wraps_d      = wraps_q;
        wrap_pulse_d = 1'b0;
        step_err_d   = 1'b0;
        fault_d      = fault_q;
        sat_d        = sat_q;

        unique case (state_q)
            StSync: begin
                bin_d      = dec;
                prev_ovf_d = bus.OverflowIn;
                state_d    = StTrack;
            end
            StTrack: begin
                if (bad_step || bad_ovf) begin
                    step_err_d = 1'b1;
                    fault_d    = 1'b1;
                    state_d    = StFault;
                end else begin
                    bin_d      = dec;
                    prev_ovf_d = bus.OverflowIn;
                    if (is_wrap) begin
                        wrap_pulse_d = 1'b1;
                        wraps_d      = (&wraps_q) ? wraps_q : wraps_q + 1'b1;
                        if (&wraps_d) begin
                            sat_d = 1'b1;
                        end
                    end
                end
            end
            StFault: begin
                if (bus.Clear) begin
                    fault_d = 1'b0;
                    state_d = StSync;
                end
            end
            default: state_d = StSync;
        endcase

        locked_d = (state_d == StTrack);
    end

    // State register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StSync;
            bin_q        <= '0;
            prev_ovf_q   <= 1'b0;
            wraps_q      <= '0;
            wrap_pulse_q <= 1'b0;
            step_err_q   <= 1'b0;
            fault_q      <= 1'b0;
            locked_q     <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            prev_ovf_q   <= prev_ovf_d;
            wraps_q      <= wraps_d;
            wrap_pulse_q <= wrap_pulse_d;
            step_err_q   <= step_err_d;
            fault_q      <= fault_d;
            locked_q     <= locked_d;
            sat_q        <= sat_d;
        end
    end

    assign bus.Bin       = bin_q;
    assign bus.Count     = {wraps_q, bin_q};
    assign bus.WrapPulse = wrap_pulse_q;
    assign bus.StepErr   = step_err_q;
    assign bus.Fault     = fault_q;
    assign bus.Locked    = locked_q;
    assign bus.Sat       = sat_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Directed bench for gray_tracker: one instance at WRAP_W=8, one at WRAP_W=2.
module tb_gray_tracker;

    logic clk;
    logic rst8;
    logic rst2;
    int   n_vec;
    int   n_err;

    // Gray code for binary 0..7.
    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};

    gray_tracker_if #(.WRAP_W(8)) u_if8 ();
    gray_tracker_if #(.WRAP_W(2)) u_if2 ();

    gray_tracker #(.WRAP_W(8)) u_dut8 (
        .Clk   (clk),
        .Reset (rst8),
        .bus   (u_if8)
    );

    gray_tracker #(.WRAP_W(2)) u_dut2 (
        .Clk   (clk),
        .Reset (rst2),
        .bus   (u_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs to the WRAP_W=8 instance, clock once, sample 1 ns after the edge.
    task automatic step8(input logic [2:0] g, input logic ovf, input logic clr, input logic rst);
        u_if8.GrayIn     = g;
        u_if8.OverflowIn = ovf;
        u_if8.Clear      = clr;
        rst8             = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [2:0] g, input logic ovf, input logic clr, input logic rst);
        u_if2.GrayIn     = g;
        u_if2.OverflowIn = ovf;
        u_if2.Clear      = clr;
        rst2             = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input int cnt, input bit wp, input bit se,
                        input bit f, input bit l, input bit s);
        check({tag, ".bin"},   32'(u_if8.Bin),       32'(cnt % 8));
        check({tag, ".count"}, 32'(u_if8.Count),     32'(cnt));
        check({tag, ".wrap"},  32'(u_if8.WrapPulse), 32'(wp));
        check({tag, ".err"},   32'(u_if8.StepErr),   32'(se));
        check({tag, ".fault"}, 32'(u_if8.Fault),     32'(f));
        check({tag, ".lock"},  32'(u_if8.Locked),    32'(l));
        check({tag, ".sat"},   32'(u_if8.Sat),       32'(s));
    endtask

    task automatic chk2(input string tag, input int cnt, input bit wp, input bit se,
                        input bit f, input bit l, input bit s);
        check({tag, ".bin"},   32'(u_if2.Bin),       32'(cnt % 8));
        check({tag, ".count"}, 32'(u_if2.Count),     32'(cnt));
        check({tag, ".wrap"},  32'(u_if2.WrapPulse), 32'(wp));
        check({tag, ".err"},   32'(u_if2.StepErr),   32'(se));
        check({tag, ".fault"}, 32'(u_if2.Fault),     32'(f));
        check({tag, ".lock"},  32'(u_if2.Locked),    32'(l));
        check({tag, ".sat"},   32'(u_if2.Sat),       32'(s));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        u_if2.GrayIn = 3'b000; u_if2.OverflowIn = 1'b0; u_if2.Clear = 1'b0; rst2 = 1'b1;

        // Reset state.
        step8(3'b000, 1'b0, 1'b0, 1'b1);
        step8(3'b000, 1'b0, 1'b0, 1'b1);
        chk8("rst", 0, 0, 0, 0, 0, 0);

        // Forward sequence: first edge syncs at 0, then 1..7.
        for (int i = 0; i < 8; i++) begin
            step8(gseq[i], 1'b0, 1'b0, 1'b0);
            chk8($sformatf("seq%0d", i), i, 0, 0, 0, 1, 0);
        end

        // First wrap with overflow rising in the same sample.
        step8(3'b000, 1'b1, 1'b0, 1'b0);
        chk8("wrap1", 8, 1, 0, 0, 1, 0);
        step8(3'b000, 1'b1, 1'b0, 1'b0);
        chk8("wrap1hold", 8, 0, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) begin
            step8(gseq[i], 1'b1, 1'b0, 1'b0);
        end
        chk8("pre_wrap2", 15, 0, 0, 0, 1, 0);
        step8(3'b000, 1'b1, 1'b0, 1'b0);
        chk8("wrap2", 16, 1, 0, 0, 1, 0);

        // Overflow falling 1->0 is illegal.
        step8(3'b000, 1'b0, 1'b0, 1'b0);
        chk8("ovf_fall", 16, 0, 1, 1, 0, 0);

        // Skip d=2 from Bin=2, then Clear resynchronises at Bin=4.
        step8(3'b000, 1'b0, 1'b0, 1'b1);
        step8(3'b000, 1'b0, 1'b0, 1'b0);
        step8(3'b001, 1'b0, 1'b0, 1'b0);
        step8(3'b011, 1'b0, 1'b0, 1'b0);
        chk8("at2", 2, 0, 0, 0, 1, 0);
        step8(3'b110, 1'b0, 1'b0, 1'b0);
        chk8("skip", 2, 0, 1, 1, 0, 0);
        step8(3'b110, 1'b0, 1'b0, 1'b0);
        chk8("fault_hold", 2, 0, 0, 1, 0, 0);
        step8(3'b110, 1'b0, 1'b1, 1'b0);
        chk8("clear", 2, 0, 0, 0, 0, 0);
        step8(3'b110, 1'b0, 1'b0, 1'b0);
        chk8("resync", 4, 0, 0, 0, 1, 0);

        // Wrap with overflow left low: error wins, no pulse, wraps unchanged.
        step8(3'b000, 1'b0, 1'b0, 1'b1);
        step8(3'b100, 1'b0, 1'b0, 1'b0);
        chk8("sync7", 7, 0, 0, 0, 1, 0);
        step8(3'b000, 1'b0, 1'b0, 1'b0);
        chk8("wrap_noovf", 7, 0, 1, 1, 0, 0);

        // Overflow rising without a wrap.
        step8(3'b000, 1'b0, 1'b0, 1'b1);
        step8(3'b011, 1'b0, 1'b0, 1'b0);
        step8(3'b011, 1'b1, 1'b0, 1'b0);
        chk8("ovf_rise", 2, 0, 1, 1, 0, 0);

        // Constant input in TRACK for 10 cycles, Clear asserted part way.
        step8(3'b000, 1'b0, 1'b0, 1'b1);
        step8(3'b011, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step8(3'b011, 1'b0, (i >= 4 && i < 7), 1'b0);
            chk8($sformatf("hold%0d", i), 2, 0, 0, 0, 1, 0);
        end
        rst8 = 1'b1;

        // Narrow wrap counter: saturation at 3, then mid-sequence reset after a fault.
        step2(3'b000, 1'b0, 1'b0, 1'b1);
        step2(3'b000, 1'b0, 1'b0, 1'b0);
        chk2("n_sync", 0, 0, 0, 0, 1, 0);
        for (int w = 1; w <= 4; w++) begin
            for (int i = 1; i < 8; i++) begin
                step2(gseq[i], (w > 1), 1'b0, 1'b0);
            end
            step2(3'b000, 1'b1, 1'b0, 1'b0);
            chk2($sformatf("n_wrap%0d", w), ((w > 3) ? 3 : w) * 8, 1, 0, 0, 1, (w >= 3));
        end
        step2(3'b011, 1'b1, 1'b0, 1'b0);
        chk2("n_skip", 24, 0, 1, 1, 0, 1);
        step2(3'b011, 1'b1, 1'b0, 1'b1);
        chk2("n_rst", 0, 0, 0, 0, 0, 0);
        step2(3'b011, 1'b1, 1'b0, 1'b0);
        chk2("n_resync", 2, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
